// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one single-port data BRAM
// between the CPU load/store port (0) and the IO/UART loader (1).
//
// Ports:
//   clk, rstn                        clock, sync active-low reset
//   req/we/addr/wdata{0,1}           requester inputs
//   gnt{0,1}                         request accepted (comb)
//   rvalid/rdata{0,1}                tagged read return
//   mem_en/we/addr/wdata, mem_rdata  BRAM side
module dmem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              last_gnt;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pid;
  logic [RD_LAT-1:0] pv_nxt;
  logic [RD_LAT-1:0] pid_nxt;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              tail_v;
  logic              tail_id;

  // On a tie the port that did not win last time goes.
  assign gnt0 = req0 & (~req1 | last_gnt);
  assign gnt1 = req1 & ~gnt0;
  assign mem_en = gnt0 | gnt1;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      gnt1: begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

  // Tag pipeline: stage k is visible k+1 cycles after the grant,
  // so the tail lines up with BRAM data RD_LAT cycles later.
  always_comb begin
    pv_nxt     = pv << 1;
    pid_nxt    = pid << 1;
    pv_nxt[0]  = mem_en & ~mem_we;
    pid_nxt[0] = gnt1;
  end

  assign tail_v  = pv[RD_LAT-1];
  assign tail_id = pid[RD_LAT-1];

  assign rvalid0 = tail_v & ~tail_id;
  assign rvalid1 = tail_v & tail_id;
  assign rdata0  = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1  = rvalid1 ? mem_rdata : rdata1_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pv       <= '0;
      pid      <= '0;
      last_gnt <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pv  <= pv_nxt;
      pid <= pid_nxt;
      if (mem_en) last_gnt <= gnt1;
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a
// BRAM model, directed scenarios and randomized traffic.
module tb_dmem_arbiter;
  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0;
  logic          req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rq_t;
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } ex_t;

  rq_t rq0[$], rq1[$];
  ex_t ex0[$], ex1[$];
  int  gseq[$];
  logic [DW-1:0] refm [int];
  logic [DW-1:0] hold0 = '0, hold1 = '0;
  bit  pend0 = 0, pend1 = 0;
  int  last_win = 1;
  int  rate = 100;
  int  cyc = 0;
  bit  mon_on = 0;
  int  tests = 0, fails = 0;

  // BRAM model: one access per cycle, data out LAT cycles later
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [LAT];
  assign mem_rdata = rpipe[LAT-1];

  function automatic logic [DW-1:0] init_val(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [DW-1:0] ref_rd(int a);
    if (refm.exists(a)) return refm[a];
    return init_val(a);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = init_val(i);
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;
    bram[16] = 32'hDEADBEEF;
    refm[16] = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? bram[mem_addr] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
    end
  endtask

  task automatic chk_seq(string n, int exp[$]);
    chk({n, "_len"}, 64'(gseq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < gseq.size(); i++)
      chk(n, 64'(gseq[i]), 64'(exp[i]));
  endtask

  // One requester cycle: present, predict grant, score it.
  task automatic step();
    bit  g0, g1;
    rq_t r;
    @(negedge clk);
    if (!pend0 && rq0.size() > 0 && $urandom_range(99) < rate)
      pend0 = 1;
    if (!pend1 && rq1.size() > 0 && $urandom_range(99) < rate)
      pend1 = 1;
    req0 = pend0;
    req1 = pend1;
    if (pend0) begin
      we0 = rq0[0].we; addr0 = rq0[0].a; wdata0 = rq0[0].d;
    end else begin
      we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
    end
    if (pend1) begin
      we1 = rq1[0].we; addr1 = rq1[0].a; wdata1 = rq1[0].d;
    end else begin
      we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
    end
    #1;
    g0 = pend0 && (!pend1 || last_win == 1);
    g1 = pend1 && !g0;
    chk("gnt0", 64'(gnt0), 64'(g0));
    chk("gnt1", 64'(gnt1), 64'(g1));
    chk("gnt_onehot", 64'(gnt0 & gnt1), 64'(0));
    chk("mem_en", 64'(mem_en), 64'(g0 | g1));
    if (g0 || g1) begin
      if (g0) r = rq0.pop_front();
      else    r = rq1.pop_front();
      chk("mem_we", 64'(mem_we), 64'(r.we));
      chk("mem_addr", 64'(mem_addr), 64'(r.a));
      if (r.we) chk("mem_wdata", 64'(mem_wdata), 64'(r.d));
      last_win = g1 ? 1 : 0;
      gseq.push_back(last_win);
      if (g0) pend0 = 0;
      else    pend1 = 0;
      if (r.we) refm[int'(r.a)] = r.d;
      else if (g0) ex0.push_back('{cyc + LAT, ref_rd(int'(r.a))});
      else         ex1.push_back('{cyc + LAT, ref_rd(int'(r.a))});
    end else begin
      chk("idle_we", 64'(mem_we), 64'(0));
      chk("idle_addr", 64'(mem_addr), 64'(0));
      chk("idle_wdata", 64'(mem_wdata), 64'(0));
    end
  endtask

  // Monitor: pops the scoreboard whenever a return is due.
  ex_t e0, e1;
  always begin
    @(negedge clk);
    #2;
    if (mon_on) begin
      if (ex0.size() > 0 && ex0[0].due == cyc) begin
        e0 = ex0.pop_front();
        chk("rvalid0", 64'(rvalid0), 64'(1));
        chk("rdata0", 64'(rdata0), 64'(e0.d));
        hold0 = e0.d;
      end else begin
        chk("rvalid0_quiet", 64'(rvalid0), 64'(0));
        chk("rdata0_hold", 64'(rdata0), 64'(hold0));
      end
      if (ex1.size() > 0 && ex1[0].due == cyc) begin
        e1 = ex1.pop_front();
        chk("rvalid1", 64'(rvalid1), 64'(1));
        chk("rdata1", 64'(rdata1), 64'(e1.d));
        hold1 = e1.d;
      end else begin
        chk("rvalid1_quiet", 64'(rvalid1), 64'(0));
        chk("rdata1_hold", 64'(rdata1), 64'(hold1));
      end
    end
  end

  task automatic do_reset(int n);
    @(negedge clk);
    rstn = 0;
    req0 = 0; req1 = 0;
    pend0 = 0; pend1 = 0;
    rq0.delete(); rq1.delete();
    repeat (n) @(posedge clk);
    #1;
    ex0.delete(); ex1.delete();
    last_win = 1;
    hold0 = '0; hold1 = '0;
    chk("rst_rvalid0", 64'(rvalid0), 64'(0));
    chk("rst_rvalid1", 64'(rvalid1), 64'(0));
    chk("rst_rdata0", 64'(rdata0), 64'(0));
    chk("rst_rdata1", 64'(rdata1), 64'(0));
    mon_on = 1;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || pend0 || pend1)
           && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n >= bound), 64'(0));
    repeat (LAT + 2) step();
    chk("ex0_empty", 64'(ex0.size()), 64'(0));
    chk("ex1_empty", 64'(ex1.size()), 64'(0));
  endtask

  function automatic rq_t mk(logic we, int a, logic [DW-1:0] d);
    rq_t r;
    r.we = we; r.a = AW'(a); r.d = d;
    return r;
  endfunction

  function automatic rq_t rnd_rq();
    int a;
    a = ($urandom_range(9) == 0) ? int'($urandom_range((1 << AW) - 1))
                                 : int'($urandom_range(31));
    return mk($urandom_range(99) < 35, a, $urandom);
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1;
    chk("init_rvalid0", 64'(rvalid0), 64'(0));
    chk("init_rvalid1", 64'(rvalid1), 64'(0));
    chk("init_rdata0", 64'(rdata0), 64'(0));
    chk("init_rdata1", 64'(rdata1), 64'(0));
    @(negedge clk);
    rstn = 1;

    // single port 0 read of preloaded word
    rate = 100;
    rq0.push_back(mk(0, 16, 0));
    drain(20);
    chk("t1_rdata0", 64'(rdata0), 64'(32'hDEADBEEF));

    // continuous contention alternates from port 0
    do_reset(1);
    gseq.delete();
    for (int i = 0; i < 3; i++) begin
      rq0.push_back(mk(0, 1, 0));
      rq1.push_back(mk(0, 2, 0));
    end
    drain(20);
    chk_seq("t2_alt", '{0, 1, 0, 1, 0, 1});

    // port 1 write then port 0 read-after-write
    rq1.push_back(mk(1, 'h100, 32'h12345678));
    step();
    rq0.push_back(mk(0, 'h100, 0));
    drain(20);
    chk("t3_raw", 64'(rdata0), 64'(32'h12345678));

    // back-to-back port 0 reads
    gseq.delete();
    for (int i = 0; i < 3; i++) rq0.push_back(mk(0, i, 0));
    drain(20);
    chk_seq("t4_b2b", '{0, 0, 0});

    // reset discards an in-flight port 1 read
    rq1.push_back(mk(0, 5, 0));
    step();
    do_reset(1);
    gseq.delete();
    rq0.push_back(mk(0, 6, 0));
    rq1.push_back(mk(0, 7, 0));
    drain(20);
    chk_seq("t5_tie", '{0, 1});

    // port 1 alone, then contention goes to port 0
    do_reset(1);
    gseq.delete();
    rq1.push_back(mk(0, 8, 0));
    step();
    rq0.push_back(mk(0, 9, 0));
    rq1.push_back(mk(0, 10, 0));
    drain(20);
    chk_seq("t6_rr", '{1, 0, 1});

    // randomized traffic with gaps
    rate = 60;
    for (int i = 0; i < 200; i++) begin
      rq0.push_back(rnd_rq());
      rq1.push_back(rnd_rq());
    end
    drain(3000);

    // random traffic interrupted by reset
    for (int i = 0; i < 40; i++) begin
      rq0.push_back(rnd_rq());
      rq1.push_back(rnd_rq());
    end
    repeat (25) step();
    do_reset(1);
    for (int i = 0; i < 60; i++) begin
      rq0.push_back(rnd_rq());
      rq1.push_back(rnd_rq());
    end
    rate = 100;
    drain(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
